// File: rtl/mems_spi_arbiter.sv
// Arbitrates scan-sequencer and host DAC words onto one shared SPI master.
// Define MEMS_ARB_ROUND_ROBIN_EN for round-robin; otherwise host has fixed priority.
module mems_spi_arbiter #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_valid,
  input  logic [DATA_W-1:0] scan_data,
  output logic              scan_ack,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              spi_busy,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  output logic              owner,
  output logic              done,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_scan_ack;
  logic                w_scan_ack_next;
  logic                r_host_ack;
  logic                w_host_ack_next;
  logic                r_spi_start;
  logic                w_spi_start_next;
  logic [DATA_W-1:0]   r_spi_data;
  logic [DATA_W-1:0]   w_spi_data_next;
  logic                r_owner;
  logic                w_owner_next;
  logic                r_done;
  logic                w_done_next;
  logic                r_timeout_err;
  logic                w_timeout_err_next;
  logic                w_any_valid;
  logic                w_pick_host;

  assign w_any_valid = scan_valid | host_valid;

`ifdef MEMS_ARB_ROUND_ROBIN_EN
  // r_owner doubles as the last-grant record; reset value 0 (scan) hands the first contest to host.
  assign w_pick_host = host_valid & (~scan_valid | ~r_owner);
`else
  assign w_pick_host = host_valid;
`endif

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_scan_ack    <= 1'b0;
      r_host_ack    <= 1'b0;
      r_spi_start   <= 1'b0;
      r_spi_data    <= '0;
      r_owner       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_scan_ack    <= w_scan_ack_next;
      r_host_ack    <= w_host_ack_next;
      r_spi_start   <= w_spi_start_next;
      r_spi_data    <= w_spi_data_next;
      r_owner       <= w_owner_next;
      r_done        <= w_done_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_scan_ack_next    = 1'b0;
    w_host_ack_next    = 1'b0;
    w_spi_start_next   = 1'b0;
    w_spi_data_next    = r_spi_data;
    w_owner_next       = r_owner;
    w_done_next        = 1'b0;
    w_timeout_err_next = r_timeout_err & ~err_clr;

    case (r_state)
      IDLE: begin
        // The cycle that shows done is kept grant-free so requesters see completion first.
        if (!spi_busy && !r_done && w_any_valid) begin
          w_spi_data_next  = w_pick_host ? host_data : scan_data;
          w_owner_next     = w_pick_host;
          w_host_ack_next  = w_pick_host;
          w_scan_ack_next  = ~w_pick_host;
          w_spi_start_next = 1'b1;
          w_state_next     = LAUNCH;
        end
      end
      LAUNCH: begin
        w_cnt_next   = '0;
        w_state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          w_state_next = WAIT_DONE;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= CNT_LAST) begin
            w_timeout_err_next = 1'b1;
            w_done_next        = 1'b1;
            w_state_next       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign scan_ack    = r_scan_ack;
  assign host_ack    = r_host_ack;
  assign spi_start   = r_spi_start;
  assign spi_data    = r_spi_data;
  assign owner       = r_owner;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/mems_spi_arbiter.md
MEMS_SPI_ARBITER -- requirements
Module: mems_spi_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 24, SPI word width; TIMEOUT, 15, max cycles after spi_start to wait for spi_busy rise.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scan_valid  input  1  scan sequencer requests a DAC word; held until scan_ack.
REQ-005 scan_data  input  DATA_W  scan word; valid while scan_valid=1.
REQ-006 scan_ack  output  1  one-cycle pulse: scan word accepted.
REQ-007 host_valid  input  1  host/config path requests a DAC word; held until host_ack.
REQ-008 host_data  input  DATA_W  host word.
REQ-009 host_ack  output  1  one-cycle pulse: host word accepted.
REQ-010 spi_busy  input  1  shared SPI master busy.
REQ-011 spi_start  output  1  one-cycle start pulse to SPI master.
REQ-012 spi_data  output  DATA_W  registered word to SPI master; stable from spi_start until next grant.
REQ-013 owner  output  1  requester of current/last grant: 0 scan, 1 host.
REQ-014 done  output  1  one-cycle pulse: transfer finished or timed out.
REQ-015 timeout_err  output  1  sticky: spi_busy never rose within TIMEOUT.
REQ-016 err_clr  input  1  clears timeout_err.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-018 IDLE: if spi_busy=0 and any valid=1 at edge N, winner selected, its data latched into spi_data, owner updated, state LAUNCH; during cycle N+1 winner ack=1 and spi_start=1.
REQ-019 IDLE with spi_busy=1 SHALL grant nothing.
REQ-020 LAUNCH lasts one cycle, then WAIT_BUSY with timeout counter cleared.
REQ-021 WAIT_BUSY: spi_busy=1 -> WAIT_DONE; else counter increments; when counter reaches TIMEOUT-1 with spi_busy still 0 -> timeout_err=1, done=1 next cycle, state IDLE.
REQ-022 WAIT_DONE: spi_busy=0 -> done=1 next cycle, state IDLE; no grant in the cycle done is high.
REQ-023 At most one ack per transfer; scan_ack and host_ack never high together.
REQ-024 Requester deasserting valid before ack: no transfer, no ack.
REQ-025 Valid arriving mid-transfer SHALL wait; no word is lost or duplicated.
REQ-026 err_clr=1 clears timeout_err next edge; simultaneous set and clear: set wins.
REQ-027 Timeout counter SHALL saturate and be width ceil(log2(TIMEOUT+1)).

Reset
REQ-028 rst=1 asynchronously forces state IDLE, counter 0, spi_start 0, scan_ack 0, host_ack 0, done 0, spi_data 0, owner 0, timeout_err 0, last-grant 0 (scan).
REQ-029 rst mid-transfer SHALL abort it with no done pulse; first grant after release follows REQ-018.

Configuration
REQ-030 Macro MEMS_ARB_ROUND_ROBIN_EN defined: on simultaneous valids, grant goes to requester not granted last (first contest after reset goes to host); single valid always granted.
REQ-031 MEMS_ARB_ROUND_ROBIN_EN undefined: fixed priority, host always wins over scan; scan granted only when host_valid=0.

Verification
REQ-032 scan_valid=1, scan_data=24'h3F1234, busy rises 2 cycles after start, held 10 cycles -> scan_ack and spi_start in same cycle, spi_data=24'h3F1234, owner=0, one done after busy falls.
REQ-033 Both valid together, three back-to-back transfers -> with _EN: host, scan, host; without: host, host, host.
REQ-034 spi_busy held 0 after spi_start -> timeout_err=1 and done pulse 15 cycles after start; err_clr=1 -> timeout_err=0.
REQ-035 host_valid during scan transfer busy phase -> host_ack only after scan done plus one IDLE cycle, host word correct.
REQ-036 rst asserted in WAIT_DONE -> all outputs 0 immediately, no done pulse; pending scan_valid granted after release.
